// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble: shift right, then
// subtract 3 from any BCD nibble >= 8). One iteration per clock, start/busy/done handshake.
module bcd_to_bin #(
  parameter int DIGITS = 6,
  parameter int BIN_W  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      bin
);

  localparam int SR_W  = 4*DIGITS + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONV = 1'b1;

  logic [0:0]       r_state;
  logic [SR_W-1:0]  r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_err;
  logic [BIN_W-1:0] r_bin;

  logic [SR_W-1:0]  w_shift;
  logic [SR_W-1:0]  w_next;
  logic             w_badDigit;
  logic             w_last;

  // Any nibble above 9 makes the request invalid; checked on the raw input at accept.
  always_comb begin
    w_badDigit = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_in[4*k +: 4] > 4'd9) begin
        w_badDigit = 1'b1;
      end
    end
  end

  // One iteration: shift the whole register right, then fix up each BCD nibble.
  always_comb begin
    w_shift = r_sr >> 1;
    w_next  = w_shift;
    for (int k = 0; k < DIGITS; k++) begin
      if (w_shift[BIN_W + 4*k +: 4] >= 4'd8) begin
        w_next[BIN_W + 4*k +: 4] = w_shift[BIN_W + 4*k +: 4] - 4'd3;
      end
    end
  end

  assign w_last = (r_cnt == CNT_W'(BIN_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_bin   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sr  <= {bcd_in, {BIN_W{1'b0}}};
            r_cnt <= '0;
            r_err <= 1'b0;
            // Invalid digits finish immediately without ever raising busy.
            if (w_badDigit) begin
              r_err  <= 1'b1;
              r_bin  <= '0;
              r_done <= 1'b1;
            end else begin
              r_state <= S_CONV;
            end
          end
        end
        S_CONV: begin
          r_sr  <= w_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_bin   <= w_next[BIN_W-1:0];
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_CONV);
  assign done = r_done;
  assign err  = r_err;
  assign bin  = r_bin;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed scenarios plus randomized digits
// checked against a decimal-arithmetic reference model.
module tb_bcd_to_bin;

  localparam int DIGITS = 6;
  localparam int BIN_W  = 20;

  logic              clk;
  logic              rst;
  logic              start;
  logic [23:0]       bcdIn;
  logic              busy;
  logic              done;
  logic              err;
  logic [BIN_W-1:0]  bin;

  int passCount  = 0;
  int checkCount = 0;

  bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bcd_in (bcdIn),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .bin    (bin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: decimal weighting of the digits, independent of the shift algorithm.
  function automatic logic [BIN_W-1:0] refBin(input logic [23:0] b);
    int v;
    int p;
    v = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      v = v + int'(b[4*i +: 4]) * p;
      p = p * 10;
    end
    return v[BIN_W-1:0];
  endfunction

  function automatic logic refErr(input logic [23:0] b);
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] > 4'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Drives one start pulse and waits (bounded) for done; lat counts cycles after the accept edge.
  task automatic runConv(input logic [23:0] bcd, output logic [BIN_W-1:0] b, output logic e,
                         output int lat, output int busyCyc, output bit tout);
    bit seen;
    seen = 1'b0;
    lat = 0;
    busyCyc = 0;
    @(negedge clk);
    start = 1'b1;
    bcdIn = bcd;
    @(posedge clk);
    #1 start = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busyCyc++;
        @(posedge clk);
        lat++;
      end
    end
    tout = !seen;
    b = bin;
    e = err;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    bcdIn = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkCount++;
    if ({busy, done, err, bin} !== {3'b000, {BIN_W{1'b0}}})
      $display("[TB] FAIL reset_state: got busy=%b done=%b err=%b bin=%h expected all 0", busy, done, err, bin);
    else passCount++;
    rst = 1'b0;
  endtask

  task automatic test_known_values();
    logic [23:0] vals [3];
    logic [BIN_W-1:0] b;
    logic e;
    int lat, bc;
    bit tout;
    vals[0] = 24'h123456;
    vals[1] = 24'h999999;
    vals[2] = 24'h000000;
    for (int i = 0; i < 3; i++) begin
      runConv(vals[i], b, e, lat, bc, tout);
      checkCount++;
      if (tout) $display("[TB] FAIL known_timeout: bcd=%h no done within 100 cycles", vals[i]);
      else passCount++;
      checkCount++;
      if (b !== refBin(vals[i]) || e !== 1'b0)
        $display("[TB] FAIL known_value: bcd=%h got bin=%h err=%b expected bin=%h err=0", vals[i], b, e, refBin(vals[i]));
      else passCount++;
      checkCount++;
      if (lat !== BIN_W || bc !== BIN_W)
        $display("[TB] FAIL known_latency: bcd=%h got lat=%0d busy=%0d expected %0d", vals[i], lat, bc, BIN_W);
      else passCount++;
    end
    repeat (3) @(negedge clk);
    checkCount++;
    if (done !== 1'b0 || bin !== refBin(24'h000000))
      $display("[TB] FAIL done_pulse_hold: got done=%b bin=%h expected done=0 bin=0", done, bin);
    else passCount++;
  endtask

  task automatic test_invalid();
    logic [BIN_W-1:0] b;
    logic e;
    int lat, bc;
    bit tout;
    runConv(24'h12A456, b, e, lat, bc, tout);
    checkCount++;
    if (tout || lat !== 0 || bc !== 0)
      $display("[TB] FAIL invalid_latency: got lat=%0d busy=%0d tout=%b expected lat=0 busy=0", lat, bc, tout);
    else passCount++;
    checkCount++;
    if (e !== 1'b1 || b !== '0)
      $display("[TB] FAIL invalid_result: got err=%b bin=%h expected err=1 bin=0", e, b);
    else passCount++;
    repeat (3) @(negedge clk);
    checkCount++;
    if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL invalid_hold: got err=%b done=%b busy=%b expected 1/0/0", err, done, busy);
    else passCount++;
    runConv(24'h000042, b, e, lat, bc, tout);
    checkCount++;
    if (tout || e !== 1'b0 || b !== 20'd42)
      $display("[TB] FAIL invalid_recover: got err=%b bin=%h expected err=0 bin=%h", e, b, 20'd42);
    else passCount++;
  endtask

  task automatic test_ignore_busy();
    int n;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    bcdIn = 24'h000100;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        if (n == 2 || n == 3 || n == 9 || n == 14) begin
          start = 1'b1;
          bcdIn = 24'h999999;
        end else begin
          start = 1'b0;
        end
        n++;
      end
    end
    start = 1'b0;
    checkCount++;
    if (!seen || n !== BIN_W)
      $display("[TB] FAIL busy_ignore_latency: got %0d cycles seen=%b expected %0d", n, seen, BIN_W);
    else passCount++;
    checkCount++;
    if (bin !== 20'd100)
      $display("[TB] FAIL busy_ignore_value: got bin=%h expected %h", bin, 20'd100);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    int n;
    bit seen;
    logic firstBusy;
    @(negedge clk);
    start = 1'b1;
    bcdIn = 24'h000321;
    @(posedge clk);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkCount++;
    if (!seen || bin !== refBin(24'h000321))
      $display("[TB] FAIL b2b_first: got bin=%h seen=%b expected %h", bin, seen, refBin(24'h000321));
    else passCount++;
    bcdIn = 24'h000007;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    seen = 1'b0;
    firstBusy = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      if (n == 0) firstBusy = busy;
      if (done) seen = 1'b1;
      else n++;
    end
    checkCount++;
    if (firstBusy !== 1'b1 || n !== BIN_W)
      $display("[TB] FAIL b2b_accept: got busy=%b lat=%0d expected busy=1 lat=%0d", firstBusy, n, BIN_W);
    else passCount++;
    checkCount++;
    if (bin !== 20'd7)
      $display("[TB] FAIL b2b_second: got bin=%h expected %h", bin, 20'd7);
    else passCount++;
  endtask

  task automatic test_reset_mid();
    logic [BIN_W-1:0] b;
    logic e;
    int lat, bc;
    bit tout;
    @(negedge clk);
    start = 1'b1;
    bcdIn = 24'h654321;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkCount++;
    if ({busy, done, err, bin} !== {3'b000, {BIN_W{1'b0}}})
      $display("[TB] FAIL reset_mid_async: got busy=%b done=%b err=%b bin=%h expected all 0", busy, done, err, bin);
    else passCount++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkCount++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL reset_mid_stray: got done=%b busy=%b expected 0/0", done, busy);
    else passCount++;
    runConv(24'h654321, b, e, lat, bc, tout);
    checkCount++;
    if (tout || lat !== BIN_W || b !== 20'h9FBF1 || e !== 1'b0)
      $display("[TB] FAIL reset_mid_rerun: got bin=%h err=%b lat=%0d expected bin=9fbf1 err=0 lat=%0d", b, e, lat, BIN_W);
    else passCount++;
  endtask

  task automatic test_random();
    logic [23:0] bcd;
    logic [BIN_W-1:0] b;
    logic e;
    int lat, bc, badPos, expLat;
    bit tout;
    for (int t = 0; t < 30; t++) begin
      badPos = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, DIGITS-1)) : -1;
      for (int d = 0; d < DIGITS; d++) begin
        if (d == badPos) bcd[4*d +: 4] = 4'($urandom_range(10, 15));
        else bcd[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      runConv(bcd, b, e, lat, bc, tout);
      expLat = refErr(bcd) ? 0 : BIN_W;
      checkCount++;
      if (tout || e !== refErr(bcd) || b !== (refErr(bcd) ? '0 : refBin(bcd)) || lat !== expLat)
        $display("[TB] FAIL random_conv: bcd=%h got bin=%h err=%b lat=%0d expected bin=%h err=%b lat=%0d",
                 bcd, b, e, lat, refErr(bcd) ? '0 : refBin(bcd), refErr(bcd), expLat);
      else passCount++;
    end
  endtask

  initial begin
    test_reset();
    test_known_values();
    test_invalid();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
- Sequential BCD-to-binary converter using reverse double-dabble (shift-right / subtract-3).
- Takes DIGITS packed 8421 BCD digits, e.g. from keypad or seven-segment entry logic, and returns an unsigned binary value.
- This is the inverse of the team's binary-to-BCD display path.
- Start/busy/done handshake; one iteration per clock.

Parameters:
- DIGITS, 6, number of BCD input digits.
- BIN_W, 20, binary output width and iteration count; must satisfy 2^BIN_W > 10^DIGITS-1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request conversion; sampled only when busy=0.
- bcd_in  input  4*DIGITS  packed digits; [3:0]=units, [7:4]=tens, ..., [4*DIGITS-1:4*DIGITS-4]=most significant.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse: bin/err valid.
- err  output  1  last request contained a digit >9.
- bin  output  BIN_W  converted value.

Behaviour:
- Reset (async, rst=1): busy=0, done=0, err=0, bin=0, state=IDLE, internal shift register and counter cleared.
- State IDLE (busy=0):
  - On an edge with start=1, bcd_in is captured into the shift register. The register holds 4*DIGITS+BIN_W bits: BCD digits in the upper part, a zeroed binary part in the lower part.
  - err is cleared, the counter is loaded with 0, and the state goes to CONV.
  - If any captured nibble >9: no conversion. On that same edge err<=1, bin<=0, done<=1, and the state stays IDLE. busy never rises, so done appears 1 cycle after the start edge.
- State CONV (busy=1): each edge performs one iteration.
  - Shift the whole register right by 1.
  - Then, for each BCD nibble of the shifted value, if the nibble >=8, subtract 3.
  - Shift and correction complete in the same cycle.
  - The counter increments. On the iteration with counter==BIN_W-1, bin<=lower BIN_W bits of the post-iteration register, done<=1, busy<=0, state<=IDLE.
- Latency: start sampled at edge E0; iterations occur at E1..E_BIN_W; done=1 and bin valid in the cycle after E_BIN_W (20 cycles after E0 by default).
- done is high for exactly one cycle. bin and err hold their values until the next completion or the next accepted start (err clears on accept).
- start while busy=1 is ignored; no queueing, and bcd_in is not re-sampled.
- start asserted in the cycle where done=1 is accepted (busy=0 there), giving back-to-back conversions with no gap.
- bcd_in only needs to be stable at the accept edge; later changes have no effect.
- Arithmetic is unsigned. The maximum 10^DIGITS-1 always fits, so there is no overflow path.
- Reset mid-conversion aborts immediately to the reset values; no done pulse is produced.

Test Plan:
- Reset, then start with bcd_in=0x123456 -> busy high for 20 cycles; done pulse with bin=0x1E240 (123456); err=0.
- bcd_in=0x999999 -> bin=0xF423F (999999). bcd_in=0x000000 -> bin=0; done after 20 iterations in both cases.
- bcd_in=0x12A456 -> done one cycle after the start edge, err=1, bin=0, busy stays 0. A following valid start with 0x000042 clears err and yields bin=42.
- start with 0x000100, then start pulses with 0x999999 during busy -> ignored; result bin=100.
- Hold start=1 continuously, changing bcd_in to 0x000007 during the done cycle -> second conversion is accepted at the edge ending the done cycle and yields 7.
- Assert rst at iteration 10 of 0x654321 -> busy/done/err/bin go to 0 asynchronously. A subsequent start of 0x654321 yields 0x9FBF1 with no stray done pulse before it.
